dram_l1_weight_fetch: RTL and testbench

//  Burst read sequencer downstream of the layer-1 weight DRAM (4-bit words, 15-bit address, 1-cycle read latency).

---
 rtl/dram_l1_weight_fetch.sv | 99 +++++++++
 tb/tb_dram_l1_weight_fetch.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/dram_l1_weight_fetch.sv
// dram_l1_weight_fetch: burst reader for layer-1 weight DRAM with a skid-buffered stream and selective (skip-unchanged) fetch
module dram_l1_weight_fetch #(
    parameter int D_WIDTH = 4,
    parameter int A_WIDTH = 15,
    parameter int L_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [A_WIDTH-1:0] base_addr,
    input  logic [L_WIDTH-1:0] burst_len,
    input  logic               skip_mode,
    output logic               busy,
    output logic               done,
    output logic [L_WIDTH-1:0] skip_cnt,
    output logic               rce,
    output logic [A_WIDTH-1:0] ra,
    input  logic [D_WIDTH-1:0] rq,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out_data,
    output logic [A_WIDTH-1:0] out_addr,
    output logic               out_changed,
    output logic               out_last
);
    localparam logic [1:0] S_IDLE = 2'd0, S_FETCH = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;
    localparam int E_W = D_WIDTH + A_WIDTH + 2;
    logic [1:0]         state_q, state_d, count_q, count_d;
    logic [A_WIDTH-1:0] addr_q, fl_addr_q;
    logic [L_WIDTH-1:0] remain_q, skip_cnt_q;
    logic [D_WIDTH-1:0] prev_q;
    logic [E_W-1:0]     b0_q, b1_q, in_e, head;
    logic               skip_q, first_q, fl_q, fl_last_q, changed, drop, push, pop;
    assign rce       = state_q == S_FETCH && ({1'b0, count_q} + {2'b0, fl_q}) < 3'd2;
    assign changed   = first_q | (rq != prev_q);
    // the final word is never dropped so the consumer always sees out_last
    assign drop      = skip_q & ~changed & ~fl_last_q;
    assign push      = fl_q & ~drop;
    assign in_e      = {fl_last_q, changed, fl_addr_q, rq};
    // an empty buffer passes the returning word straight through
    assign head      = count_q != 2'd0 ? b0_q : push ? in_e : '0;
    assign out_valid = count_q != 2'd0 | push;
    assign pop       = out_valid & out_ready;
    assign {out_last, out_changed, out_addr, out_data} = head;
    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;
    assign skip_cnt  = skip_cnt_q;
    assign ra        = addr_q;
    always_comb begin
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        state_d = state_q == S_IDLE  ? (start ? (burst_len == '0 ? S_DONE : S_FETCH) : S_IDLE)
                : state_q == S_FETCH ? (rce && remain_q == L_WIDTH'(1) ? S_DRAIN : S_FETCH)
                : state_q == S_DRAIN ? (count_d == 2'd0 ? S_DONE : S_DRAIN)
                : S_IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            addr_q     <= '0;
            fl_addr_q  <= '0;
            remain_q   <= '0;
            skip_cnt_q <= '0;
            prev_q     <= '0;
            b0_q       <= '0;
            b1_q       <= '0;
            skip_q     <= 1'b0;
            first_q    <= 1'b0;
            fl_q       <= 1'b0;
            fl_last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            fl_q    <= rce;
            if (state_q == S_IDLE && start) begin
                addr_q     <= base_addr;
                remain_q   <= burst_len;
                skip_q     <= skip_mode;
                first_q    <= 1'b1;
                prev_q     <= '0;
                skip_cnt_q <= '0;
            end
            if (rce) begin
                addr_q    <= addr_q + 1'b1;
                remain_q  <= remain_q - 1'b1;
                fl_addr_q <= addr_q;
                fl_last_q <= remain_q == L_WIDTH'(1);
            end
            if (fl_q) begin
                prev_q  <= rq;
                first_q <= 1'b0;
                if (drop) skip_cnt_q <= skip_cnt_q + 1'b1;
            end
            if ((count_q == 2'd0 && push && !pop) || (count_q == 2'd1 && push && pop)) b0_q <= in_e;
            else if (count_q == 2'd2 && pop) b0_q <= b1_q;
            if (push && ((count_q == 2'd1 && !pop) || (count_q == 2'd2 && pop))) b1_q <= in_e;
        end
    end
endmodule

// File: tb/tb_dram_l1_weight_fetch.sv
// tb_dram_l1_weight_fetch: directed bench for the weight fetch sequencer with a 1-cycle-latency DRAM model
module tb_dram_l1_weight_fetch;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, skip_mode = 1'b0, out_ready = 1'b1;
    logic [14:0] base_addr = '0;
    logic [15:0] burst_len = '0;
    logic        busy, done, rce, out_valid, out_changed, out_last;
    logic [15:0] skip_cnt;
    logic [14:0] ra, out_addr;
    logic [3:0]  rq = '0, out_data;
    logic [3:0]  mem [0:32767];
    int n_checks = 0, n_errors = 0;
    logic [3:0]  q_data[$];
    logic [14:0] q_addr[$], q_ra[$];
    logic        q_chg[$], q_last[$];
    int first_valid, done_cyc, done_cnt;

    dram_l1_weight_fetch dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .burst_len(burst_len),
        .skip_mode(skip_mode), .busy(busy), .done(done), .skip_cnt(skip_cnt), .rce(rce), .ra(ra),
        .rq(rq), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_changed(out_changed), .out_last(out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (rce) rq <= mem[ra];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {busy, done, skip_cnt, rce, ra, out_valid, out_data, out_addr, out_changed, out_last};
    endfunction

    task automatic run(input logic [14:0] b, input logic [15:0] l, input logic s, input bit toggle,
                       input int restart_c, input int rst_after);
        int issued = 0, accepted = 0;
        bit stalled = 0;
        logic [20:0] cur, saved = '0;
        q_data.delete(); q_addr.delete(); q_ra.delete(); q_chg.delete(); q_last.delete();
        first_valid = -1; done_cyc = -1; done_cnt = 0;
        base_addr = b; burst_len = l; skip_mode = s; start = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            start = (c == restart_c);
            if (c == restart_c) begin base_addr = 15'h50; burst_len = 16'd2; end
            out_ready = !toggle || (c % 3 == 1);
            if (rst) begin
                check("rst_outputs_zero", outs(), 64'd0);
                rst = 1'b0;
                break;
            end
            cur = {out_data, out_addr, out_changed, out_last};
            if (stalled) check("stall_hold", {out_valid, cur}, {1'b1, saved});
            if (rce) begin
                if (toggle) check("rce_room", 64'(issued - accepted < 2), 64'd1);
                q_ra.push_back(ra);
                issued++;
            end
            if (out_valid && first_valid < 0) first_valid = c;
            if (out_valid && out_ready) begin
                q_data.push_back(out_data); q_addr.push_back(out_addr);
                q_chg.push_back(out_changed); q_last.push_back(out_last);
                accepted++;
            end
            stalled = out_valid && !out_ready;
            saved = cur;
            if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
            if (accepted == rst_after) rst = 1'b1;
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        start = 1'b0; out_ready = 1'b1;
        if (rst_after < 0 && done_cyc < 0) check("done_seen", 64'd0, 64'd1);
    endtask

    task automatic check_t1(input string p);
        check({p, "_count"}, 64'(q_data.size()), 64'd4);
        if (q_data.size() == 4) begin
            check({p, "_data"}, {q_data[0], q_data[1], q_data[2], q_data[3]}, 64'h3377);
            check({p, "_chg"}, {q_chg[0], q_chg[1], q_chg[2], q_chg[3]}, 64'b1010);
            check({p, "_last"}, {q_last[0], q_last[1], q_last[2], q_last[3]}, 64'b0001);
            check({p, "_addr3"}, 64'(q_addr[3]), 64'h13);
        end
        check({p, "_first_valid"}, 64'(first_valid), 64'd2);
        check({p, "_done_cyc"}, 64'(done_cyc), 64'd6);
        check({p, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check({p, "_skip_cnt"}, 64'(skip_cnt), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 4'd0;
        mem[15'h10] = 4'd3; mem[15'h11] = 4'd3; mem[15'h12] = 4'd7; mem[15'h13] = 4'd7;
        mem[15'h7FFE] = 4'd1; mem[15'h7FFF] = 4'd2; mem[15'h0] = 4'd4; mem[15'h1] = 4'd8;
        for (int i = 0; i < 8; i++) mem[15'h100 + i] = 4'(i + 1);
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_zero", outs(), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_not_busy", 64'(busy), 64'd0);

        run(15'h10, 16'd4, 1'b0, 1'b0, -1, -1);
        check_t1("t1");
        check("t1_busy_after", 64'(busy), 64'd0);

        run(15'h10, 16'd4, 1'b1, 1'b0, -1, -1);
        check("t2_count", 64'(q_data.size()), 64'd3);
        if (q_data.size() == 3) begin
            check("t2_data", {q_data[0], q_data[1], q_data[2]}, 64'h377);
            check("t2_chg", {q_chg[0], q_chg[1], q_chg[2]}, 64'b110);
            check("t2_last", {q_last[0], q_last[1], q_last[2]}, 64'b001);
        end
        check("t2_skip_cnt", 64'(skip_cnt), 64'd1);
        check("t2_done_cnt", 64'(done_cnt), 64'd1);

        run(15'h7FFE, 16'd4, 1'b0, 1'b0, -1, -1);
        check("t3_reads", 64'(q_ra.size()), 64'd4);
        if (q_ra.size() == 4) check("t3_ra", {q_ra[0], q_ra[1], q_ra[2], q_ra[3]}, {15'h7FFE, 15'h7FFF, 15'h0, 15'h1});
        check("t3_count", 64'(q_data.size()), 64'd4);
        if (q_data.size() == 4) begin
            check("t3_addr", {q_addr[0], q_addr[1], q_addr[2], q_addr[3]}, {15'h7FFE, 15'h7FFF, 15'h0, 15'h1});
            check("t3_data", {q_data[0], q_data[1], q_data[2], q_data[3]}, 64'h1248);
            check("t3_last", {q_last[0], q_last[1], q_last[2], q_last[3]}, 64'b0001);
        end

        run(15'h100, 16'd8, 1'b0, 1'b1, -1, -1);
        check("t4_count", 64'(q_data.size()), 64'd8);
        if (q_data.size() == 8)
            for (int i = 0; i < 8; i++)
                check("t4_word", {q_data[i], q_addr[i], q_chg[i], q_last[i]}, {4'(i + 1), 15'(15'h100 + i), 1'b1, i == 7});
        check("t4_done_cnt", 64'(done_cnt), 64'd1);

        run(15'h10, 16'd0, 1'b0, 1'b0, -1, -1);
        check("t5_done_cyc", 64'(done_cyc), 64'd1);
        check("t5_done_cnt", 64'(done_cnt), 64'd1);
        check("t5_no_rce", 64'(q_ra.size()), 64'd0);
        check("t5_no_valid", 64'(first_valid < 0), 64'd1);
        run(15'h10, 16'd4, 1'b0, 1'b0, 2, -1);
        check("t5_busy_start_reads", 64'(q_ra.size()), 64'd4);
        if (q_ra.size() == 4) check("t5_busy_start_ra3", 64'(q_ra[3]), 64'h13);
        check_t1("t5b");

        run(15'h100, 16'd8, 1'b0, 1'b0, -1, 3);
        check("t6_words_before_rst", 64'(q_data.size()), 64'd3);
        check("t6_no_done", 64'(done_cnt), 64'd0);
        run(15'h10, 16'd4, 1'b0, 1'b0, -1, -1);
        check_t1("t6_after");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
